// File: rtl/adc_input_conditioner.sv
// ADC front end: buffers raw codes, centres them on an offset, scales by 2^scale_exp
// and emits IEEE-754 singles one at a time. Define ADC_COND_OVERFLOW_EN for a sticky drop flag.
module adc_input_conditioner #(
  parameter int ADC_WL     = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int WL         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_WL-1:0] adc_code,
  input  logic              adc_valid,
  input  logic [ADC_WL-1:0] offset,
  input  logic signed [7:0] scale_exp,
  input  logic              x_output_ready,
  output logic [WL-1:0]     x_centered_scaled,
  output logic              x_centered_scaled_in_ready,
  output logic              fifo_full,
  output logic              busy,
  output logic              overflow
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int DW  = ADC_WL + 1;
  localparam int PIW = $clog2(DW);
  localparam int MW  = 23;

  typedef enum logic [2:0] {IDLE, CENTER, NORM, ISSUE, WAIT_NLC} state_e;

  state_e state_q, state_d;

  logic [ADC_WL-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  logic [ADC_WL-1:0]    sample_q;
  logic signed [DW-1:0] diff_q;
  logic [31:0]          word_q, word_d;
  logic [WL-1:0]        x_out_q;
  logic                 strobe_q;

  // A push is judged against the registered full flag, so a simultaneous pop never rescues it.
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign push      = adc_valid && !fifo_full;
  assign busy      = (state_q != IDLE);

  // NOTE: storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= adc_code;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = CENTER;
        end
      end
      CENTER:   state_d = NORM;
      NORM:     state_d = ISSUE;
      ISSUE:    state_d = WAIT_NLC;
      WAIT_NLC: if (x_output_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Float packing: magnitude, leading-one position and biased, scaled exponent.
  logic              sign;
  logic [DW-1:0]     mag;
  logic [PIW-1:0]    msb_idx;
  logic [MW-1:0]     mant;
  logic signed [9:0] exp_s;

  always_comb begin
    sign    = diff_q[DW-1];
    mag     = sign ? DW'(-diff_q) : DW'(diff_q);
    msb_idx = '0;
    for (int i = 0; i < DW; i++) begin
      if (mag[i]) msb_idx = PIW'(i);
    end
    // Bits below the leading one slide up to the top of the 23-bit field; exact, no rounding.
    mant  = MW'({{MW{1'b0}}, mag} << (MW - int'(msb_idx)));
    exp_s = 10'sd127 + $signed({{(10-PIW){1'b0}}, msb_idx})
          + $signed({{2{scale_exp[7]}}, scale_exp});
    if (mag == '0)              word_d = 32'h0000_0000;
    else if (exp_s > 10'sd254)  word_d = {sign, 31'h7F7F_FFFF};
    else if (exp_s < 10'sd1)    word_d = {sign, 31'h0000_0000};
    else                        word_d = {sign, exp_s[7:0], mant};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      diff_q   <= '0;
      word_q   <= '0;
      x_out_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (pop) sample_q <= mem_q[rd_ptr_q];
      if (state_q == CENTER) diff_q <= $signed({1'b0, sample_q}) - $signed({1'b0, offset});
      if (state_q == NORM)   word_q <= word_d;
      if (state_q == ISSUE) begin
        x_out_q  <= WL'(word_q);
        strobe_q <= 1'b1;
      end
    end
  end

  assign x_centered_scaled          = x_out_q;
  assign x_centered_scaled_in_ready = strobe_q;

`ifdef ADC_COND_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      overflow_q <= 1'b0;
    else if (adc_valid && fifo_full) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/adc_input_conditioner.md
ADC_INPUT_CONDITIONER -- requirements
Module: adc_input_conditioner

Interface
REQ-001 Parameter ADC_WL, default 14: raw ADC code width.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries, power of two.
REQ-003 Parameter WL, default 32: output word width (IEEE-754 single).
REQ-004 clk  input  1  system clock; every register updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 adc_code  input  ADC_WL  raw unsigned ADC sample.
REQ-007 adc_valid  input  1  adc_code valid this cycle.
REQ-008 offset  input  ADC_WL  unsigned centering code; static while busy.
REQ-009 scale_exp  input  8  signed two's-complement power-of-two scale; static while busy.
REQ-010 x_output_ready  input  1  downstream NLC done pulse; frees the stage.
REQ-011 x_centered_scaled  output  WL  centered, scaled float sample.
REQ-012 x_centered_scaled_in_ready  output  1  one-cycle strobe marking x_centered_scaled valid.
REQ-013 fifo_full  output  1  buffer holds FIFO_DEPTH entries.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 overflow  output  1  sticky dropped-sample flag.

Function
REQ-016 Push: adc_valid=1 and fifo_full=0 writes adc_code; fifo_full is the registered value, so a push while full is dropped even if a pop occurs in the same cycle.
REQ-017 Push and pop in the same cycle with count not full: count unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states: IDLE, CENTER, NORM, ISSUE, WAIT_NLC.
REQ-019 IDLE: FIFO non-empty -> pop head, go CENTER; else stay.
REQ-020 CENTER: diff = adc_code - offset as signed (ADC_WL+1)-bit; go NORM.
REQ-021 NORM: sign = diff msb; mag = |diff|; p = msb index of mag; exponent e = 127 + p + scale_exp, computed signed 10-bit; mantissa = mag bits below p, left-aligned to 23 bits, zero-filled (exact, no rounding); go ISSUE.
REQ-022 diff = 0 -> output 0x00000000.
REQ-023 e > 254 -> saturate to sign | 0x7F7FFFFF; e < 1 -> flush to sign | 0x00000000.
REQ-024 ISSUE: register x_centered_scaled, pulse x_centered_scaled_in_ready for exactly one cycle; go WAIT_NLC.
REQ-025 Latency: strobe asserts 4 cycles after the pop edge in IDLE (IDLE->CENTER->NORM->ISSUE->strobe registered).
REQ-026 WAIT_NLC: x_output_ready=1 -> IDLE; x_output_ready in any other state is ignored.
REQ-027 x_centered_scaled holds its value until the next ISSUE.
REQ-028 Pushes continue in all states, including WAIT_NLC.

Reset
REQ-029 reset=0 asynchronously forces IDLE, empties the FIFO, and clears x_centered_scaled, strobe, fifo_full, busy and overflow to 0.
REQ-030 Reset mid-conversion discards the in-flight sample and all buffered samples; no strobe after release until a new push.
REQ-031 First push accepted on the first rising edge with reset=1.

Configuration
REQ-032 Macro ADC_COND_OVERFLOW_EN defined: overflow sets on any dropped push and stays set until reset.
REQ-033 ADC_COND_OVERFLOW_EN undefined: overflow is tied 0, no sticky logic; dropping behaviour is unchanged.

Verification
REQ-034 offset=8192, scale_exp=-13, adc_code=8193 -> x_centered_scaled=0x39000000, strobe 4 cycles after pop.
REQ-035 offset=8192, scale_exp=-13, adc_code=0 -> 0xBF800000; adc_code=16383 -> 0x3F7FF800; adc_code=8192 -> 0x00000000.
REQ-036 offset=8192, scale_exp=+127, adc_code=16383 -> 0x7F7FFFFF; scale_exp=-128, adc_code=8193 -> 0x00000000.
REQ-037 x_output_ready held 0, 6 consecutive adc_valid cycles -> 5 accepted, fifo_full=1, 6th dropped, overflow=1 (macro on) or 0 (macro off); then pulse x_output_ready 4 times -> 4 further strobes in push order.
REQ-038 reset=0 asserted during NORM with 2 samples buffered -> outputs 0 immediately, no strobe after release.
REQ-039 x_output_ready pulsed in IDLE and CENTER -> ignored; state sequence unchanged.
